// File: rtl/node_array_mac_if.sv
// Producer/consumer bundle for node_array_mac: vector start, element stream and result handshake.
// The master side is the one that feeds vectors and takes results; the block itself uses the slave side.
interface node_array_mac_if #(
  parameter int NUM_NODES = 4,
  parameter int DATA_W    = 16
) ();
  logic                          start;
  logic [NUM_NODES*DATA_W-1:0]   bias;
  logic [1:0]                    act_mode;
  logic                          in_valid;
  logic                          in_ready;
  logic [DATA_W-1:0]             in_data;
  logic [NUM_NODES*DATA_W-1:0]   coef;
  logic                          out_valid;
  logic                          out_ready;
  logic [NUM_NODES*DATA_W-1:0]   node_out;
  logic [NUM_NODES-1:0]          sat_flag;
  logic                          busy;

  modport master (
    output start, bias, act_mode, in_valid, in_data, coef, out_ready,
    input  in_ready, out_valid, node_out, sat_flag, busy
  );

  modport slave (
    input  start, bias, act_mode, in_valid, in_data, coef, out_ready,
    output in_ready, out_valid, node_out, sat_flag, busy
  );
endinterface

// File: rtl/node_array_mac.sv
// NUM_NODES parallel fixed-point neurons over one streamed input vector: bias load, wide MAC,
// output saturation and a selectable activation, with valid/ready on both sides.
module node_array_mac #(
  parameter int NUM_NODES  = 4,
  parameter int IMAGE_SIZE = 64,
  parameter int DATA_W     = 16,
  parameter int FRAC_W     = 8,
  parameter int ACC_W      = 40
) (
  input  logic             clk,
  input  logic             rst,
  node_array_mac_if.slave  bus
);

  localparam int CNT_W = $clog2(IMAGE_SIZE);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMAGE_SIZE - 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic signed [DATA_W-1:0] ONE    = DATA_W'(1 << FRAC_W);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_ACTIVATE, S_OUTPUT} state_e;
  typedef enum logic [1:0] {ACT_IDENT = 2'b00, ACT_RELU = 2'b01,
                            ACT_LEAKY = 2'b10, ACT_CLIP = 2'b11} act_e;

  typedef struct packed {
    logic signed [DATA_W-1:0] data;
    logic                     sat;
  } act_res_t;

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            count_q, count_d;
  act_e                        mode_q, mode_d;
  logic signed [ACC_W-1:0]     acc_q [NUM_NODES];
  logic signed [ACC_W-1:0]     acc_d [NUM_NODES];
  logic [NUM_NODES*DATA_W-1:0] node_out_q, node_out_d;
  logic [NUM_NODES-1:0]        sat_q, sat_d;

  logic signed [2*DATA_W-1:0]  prod [NUM_NODES];
  act_res_t                    act_r [NUM_NODES];

  // Rescale to the output Q format, clamp to DATA_W, then apply the activation to the clamped value.
  function automatic act_res_t activate(input logic signed [ACC_W-1:0] acc, input act_e mode);
    logic signed [ACC_W-1:0]  v;
    logic signed [DATA_W-1:0] c;
    act_res_t                 r;
    v     = acc >>> FRAC_W;
    r.sat = 1'b0;
    if (v > SAT_MAX) begin
      c     = SAT_MAX[DATA_W-1:0];
      r.sat = 1'b1;
    end else if (v < SAT_MIN) begin
      c     = SAT_MIN[DATA_W-1:0];
      r.sat = 1'b1;
    end else begin
      c = v[DATA_W-1:0];
    end
    unique case (mode)
      ACT_IDENT: r.data = c;
      ACT_RELU:  r.data = (c < 0) ? '0 : c;
      ACT_LEAKY: r.data = (c < 0) ? (c >>> 3) : c;
      ACT_CLIP:  r.data = (c < 0) ? '0 : ((c > ONE) ? ONE : c);
      default:   r.data = c;
    endcase
    return r;
  endfunction

  always_comb begin
    for (int n = 0; n < NUM_NODES; n++) begin
      prod[n]  = $signed(bus.in_data) * $signed(bus.coef[n*DATA_W +: DATA_W]);
      act_r[n] = activate(acc_q[n], mode_q);
    end
  end

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case can infer a latch.
    state_d    = state_q;
    count_d    = count_q;
    mode_d     = mode_q;
    acc_d      = acc_q;
    node_out_d = node_out_q;
    sat_d      = sat_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          for (int n = 0; n < NUM_NODES; n++) begin
            acc_d[n] = {{(ACC_W-DATA_W){bus.bias[n*DATA_W+DATA_W-1]}},
                        bus.bias[n*DATA_W +: DATA_W]} << FRAC_W;
          end
          mode_d  = act_e'(bus.act_mode);
          count_d = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (bus.in_valid) begin
          for (int n = 0; n < NUM_NODES; n++) begin
            acc_d[n] = acc_q[n] + {{(ACC_W-2*DATA_W){prod[n][2*DATA_W-1]}}, prod[n]};
          end
          if (count_q == LAST_IDX) begin
            count_d = '0;
            state_d = S_ACTIVATE;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      S_ACTIVATE: begin
        for (int n = 0; n < NUM_NODES; n++) begin
          node_out_d[n*DATA_W +: DATA_W] = act_r[n].data;
          sat_d[n]                       = act_r[n].sat;
        end
        state_d = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      mode_q     <= ACT_IDENT;
      // NOTE: the accumulator array is reset too; a discarded vector must leave no residue visible.
      acc_q      <= '{default: '0};
      node_out_q <= '0;
      sat_q      <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      mode_q     <= mode_d;
      acc_q      <= acc_d;
      node_out_q <= node_out_d;
      sat_q      <= sat_d;
    end
  end

  assign bus.in_ready  = (state_q == S_ACCUM);
  assign bus.out_valid = (state_q == S_OUTPUT);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.node_out  = node_out_q;
  assign bus.sat_flag  = sat_q;

endmodule

// File: tb/tb_node_array_mac.sv
// Directed bench for node_array_mac (Q8.8, 4 nodes, 64 elements): identity, sign/activation,
// saturation, bias/clip, handshake stalls and mid-vector reset.
module tb_node_array_mac;

  localparam int NN = 4;
  localparam int IS = 64;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  node_array_mac_if #(.NUM_NODES(NN), .DATA_W(DW)) bus ();

  node_array_mac #(
    .NUM_NODES(NN), .IMAGE_SIZE(IS), .DATA_W(DW), .FRAC_W(8), .ACC_W(40)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    bus.start     = 1'b0;
    bus.bias      = '0;
    bus.act_mode  = 2'b00;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.coef      = '0;
    bus.out_ready = 1'b0;
  endtask

  // Entered and left at a falling edge; start is taken on the rising edge in between.
  task automatic start_vec(input logic [63:0] bias, input logic [1:0] mode);
    bus.start    = 1'b1;
    bus.bias     = bias;
    bus.act_mode = mode;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  // Offers elements until cnt are accepted; optionally inserts gaps and pokes start/bias/mode.
  task automatic feed(input int cnt, input logic [15:0] data, input logic [63:0] coef,
                      input bit gaps, input bit poke, output int accepted);
    int cyc;
    bit gap;
    cyc      = 0;
    accepted = 0;
    while (accepted < cnt && cyc < 1000) begin
      gap          = gaps && ($urandom_range(0, 2) == 0);
      bus.in_valid = !gap;
      bus.in_data  = data;
      bus.coef     = coef;
      if (poke) begin
        bus.start    = ((accepted % 7) == 3);
        bus.act_mode = 2'b11;
        bus.bias     = {4{16'h7000}};
      end
      if (!gap && bus.in_ready === 1'b1) accepted++;
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
  endtask

  // Entered at the falling edge after the last accept; lat counts falling edges until out_valid.
  task automatic finish_vec(output logic [63:0] got, output logic [3:0] gs,
                            output int lat, output logic idle_after);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got           = bus.node_out;
    gs            = bus.sat_flag;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    idle_after    = (bus.busy === 1'b0 && bus.out_valid === 1'b0);
  endtask

  task automatic run_vec(input logic [63:0] bias, input logic [1:0] mode, input logic [15:0] data,
                         input logic [63:0] coef, output logic [63:0] got, output logic [3:0] gs,
                         output int lat, output logic idle_after);
    int acc_n;
    start_vec(bias, mode);
    feed(IS, data, coef, 1'b0, 1'b0, acc_n);
    finish_vec(got, gs, lat, idle_after);
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b exp=0", bus.busy); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset in_ready got=%b exp=0", bus.in_ready); end
    total++; if (bus.node_out !== 64'h0) begin bad++; $display("FAIL reset node_out got=%h exp=0", bus.node_out); end
    total++; if (bus.sat_flag !== 4'h0) begin bad++; $display("FAIL reset sat_flag got=%b exp=0", bus.sat_flag); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_identity();
    logic [63:0] got; logic [3:0] gs; int lat; logic idle;
    run_vec(64'h0, 2'b00, 16'h0100, {4{16'h0100}}, got, gs, lat, idle);
    total++; if (lat !== 1) begin bad++; $display("FAIL identity latency got=%0d exp=1", lat); end
    total++; if (got !== {4{16'h4000}}) begin bad++; $display("FAIL identity node_out got=%h exp=%h", got, {4{16'h4000}}); end
    total++; if (gs !== 4'h0) begin bad++; $display("FAIL identity sat_flag got=%b exp=0000", gs); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL identity return_idle got=%b exp=1", idle); end
  endtask

  task automatic test_sign_act();
    logic [15:0] exp_tab [4];
    logic [63:0] got; logic [3:0] gs; int lat; logic idle;
    exp_tab = '{16'hC000, 16'h0000, 16'hF800, 16'h0000};
    for (int m = 0; m < 4; m++) begin
      run_vec(64'h0, 2'(m), 16'h0100, {4{16'hFF00}}, got, gs, lat, idle);
      total++; if (got !== {4{exp_tab[m]}}) begin bad++; $display("FAIL sign_act mode%0d node_out got=%h exp=%h", m, got, {4{exp_tab[m]}}); end
      total++; if (gs !== 4'h0) begin bad++; $display("FAIL sign_act mode%0d sat_flag got=%b exp=0000", m, gs); end
    end
  endtask

  task automatic test_saturation();
    logic [63:0] got; logic [3:0] gs; int lat; logic idle;
    run_vec(64'h0, 2'b00, 16'h7FFF, {16'h0000, 16'h0000, 16'h8001, 16'h7FFF}, got, gs, lat, idle);
    total++; if (got !== {16'h0000, 16'h0000, 16'h8000, 16'h7FFF}) begin bad++; $display("FAIL saturation node_out got=%h exp=0000000080007fff", got); end
    total++; if (gs !== 4'b0011) begin bad++; $display("FAIL saturation sat_flag got=%b exp=0011", gs); end
  endtask

  task automatic test_bias_clip();
    logic [63:0] got; logic [3:0] gs; int lat; logic idle;
    run_vec({4{16'h0080}}, 2'b00, 16'h0100, 64'h0, got, gs, lat, idle);
    total++; if (got !== {4{16'h0080}}) begin bad++; $display("FAIL bias node_out got=%h exp=%h", got, {4{16'h0080}}); end
    run_vec({16'h0200, 16'hFF00, 16'h0080, 16'h0200}, 2'b11, 16'h0100, 64'h0, got, gs, lat, idle);
    total++; if (got !== {16'h0100, 16'h0000, 16'h0080, 16'h0100}) begin bad++; $display("FAIL clip node_out got=%h exp=0100000000800100", got); end
    total++; if (gs !== 4'h0) begin bad++; $display("FAIL clip sat_flag got=%b exp=0000", gs); end
  endtask

  // Gapped input, start/bias/mode poked mid-vector, 10-cycle output stall, start held at handshake.
  task automatic test_handshake();
    int acc_n;
    int stall_bad;
    start_vec(64'h0, 2'b00);
    feed(IS, 16'h0100, {4{16'h0100}}, 1'b1, 1'b1, acc_n);
    total++; if (acc_n !== IS) begin bad++; $display("FAIL handshake accepted got=%0d exp=%0d", acc_n, IS); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL handshake early_valid got=%b exp=0", bus.out_valid); end
    @(negedge clk);
    stall_bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.out_valid !== 1'b1 || bus.node_out !== {4{16'h4000}} || bus.sat_flag !== 4'h0) stall_bad++;
      @(negedge clk);
    end
    total++; if (stall_bad !== 0) begin bad++; $display("FAIL handshake stall_stable got=%0d_bad_cycles exp=0 node_out=%h", stall_bad, bus.node_out); end
    bus.bias      = '0;
    bus.act_mode  = 2'b00;
    bus.start     = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL handshake idle_after_output got=%b exp=0", bus.busy); end
    @(negedge clk);
    bus.start = 1'b0;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL handshake start_resampled got=%b exp=1", bus.busy); end
  endtask

  // Continues the vector begun at the end of test_handshake; reset after 10 accepts.
  task automatic test_reset_midrun();
    int acc_n;
    logic [63:0] got; logic [3:0] gs; int lat; logic idle;
    feed(10, 16'h0100, {4{16'h0100}}, 1'b0, 1'b0, acc_n);
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL midreset ctrl got=%b%b%b exp=000", bus.busy, bus.in_ready, bus.out_valid); end
    total++; if (bus.node_out !== 64'h0 || bus.sat_flag !== 4'h0) begin bad++; $display("FAIL midreset outputs got=%h/%b exp=0/0000", bus.node_out, bus.sat_flag); end
    rst = 1'b0;
    @(negedge clk);
    run_vec(64'h0, 2'b00, 16'h0100, {4{16'h0100}}, got, gs, lat, idle);
    total++; if (got !== {4{16'h4000}}) begin bad++; $display("FAIL midreset rerun node_out got=%h exp=%h", got, {4{16'h4000}}); end
    total++; if (lat !== 1) begin bad++; $display("FAIL midreset rerun latency got=%0d exp=1", lat); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_sign_act();
    test_saturation();
    test_bias_clip();
    test_handshake();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
